// File: rtl/filter_mixer.sv
// SID filter mixer: routes voices into the filter input, mixes the filter outputs with direct voices, saturates and applies master volume.
// Optional MIXER_EXT_IN_EN routes iExt into the filter or the direct path; timing is identical in both builds.
module filter_mixer #(
  parameter int ACC_W = 19,
  parameter int VOL_W = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               clkEn,
  input  logic               WR,
  input  logic [4:0]         ADDR,
  input  logic [7:0]         DATA,
  input  logic signed [15:0] iVoice0,
  input  logic signed [15:0] iVoice1,
  input  logic signed [15:0] iVoice2,
  input  logic signed [15:0] iExt,
  input  logic signed [15:0] iLP,
  input  logic signed [15:0] iBP,
  input  logic signed [15:0] iHP,
  output logic signed [15:0] oFilterIn,
  output logic signed [15:0] oOut,
  output logic               oValid
);

  localparam int PROD_W = 16 + VOL_W;
  localparam int CNT_W  = (VOL_W > 1) ? $clog2(VOL_W) : 1;

  typedef enum logic [3:0] {
    IDLE, ACC0, ACC1, ACC2, ACC3, FLT_LP, FLT_BP, FLT_HP, SAT, MUL, DONE
  } state_t;

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [15:0] v);
    return {{(ACC_W-16){v[15]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    if (!a[ACC_W-1] && (|a[ACC_W-2:15]))      return 16'sh7fff;
    else if (a[ACC_W-1] && !(&a[ACC_W-2:15])) return 16'sh8000;
    else                                      return a[15:0];
  endfunction

  state_t                    state;
  logic [3:0]                reg_filt, filt_s;
  logic [7:0]                reg_mode, mode_s;
  logic signed [15:0]        v0_s, v1_s, v2_s, lp_s, bp_s, hp_s;
  logic signed [ACC_W-1:0]   acc_filt, acc_dir, f_ext, ext_filt, ext_dir;
  logic signed [15:0]        mix_s;
  logic signed [PROD_W-1:0]  product, mcand, prod_sh;
  logic [VOL_W-1:0]          vol_sh;
  logic [CNT_W-1:0]          mul_cnt;

`ifdef MIXER_EXT_IN_EN
  logic signed [15:0] ext_s;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)      ext_s <= '0;
    else if (clkEn) ext_s <= iExt;
  end
`else
  logic ext_unused;
  assign ext_unused = ^{iExt, filt_s[3]};
`endif

  always_comb begin
    ext_filt = '0;
    ext_dir  = '0;
`ifdef MIXER_EXT_IN_EN
    if (filt_s[3]) ext_filt = sx(ext_s);
    else           ext_dir  = sx(ext_s);
`endif
    f_ext   = acc_filt + ext_filt;
    mix_s   = sat16(acc_dir);
    prod_sh = product >>> VOL_W;
  end

  // Register file; the snapshot below samples the pre-write value on a shared edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      reg_filt <= '0;
      reg_mode <= '0;
    end else if (WR) begin
      case (ADDR)
        5'h17:   reg_filt <= DATA[3:0];
        5'h18:   reg_mode <= DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      filt_s    <= '0;
      mode_s    <= '0;
      v0_s      <= '0;
      v1_s      <= '0;
      v2_s      <= '0;
      lp_s      <= '0;
      bp_s      <= '0;
      hp_s      <= '0;
      acc_filt  <= '0;
      acc_dir   <= '0;
      product   <= '0;
      mcand     <= '0;
      vol_sh    <= '0;
      mul_cnt   <= '0;
      oFilterIn <= '0;
      oOut      <= '0;
      oValid    <= 1'b0;
    end else begin
      oValid <= 1'b0;
      if (clkEn) begin
        // A strobe always wins: any sample in flight is dropped.
        filt_s   <= reg_filt;
        mode_s   <= reg_mode;
        v0_s     <= iVoice0;
        v1_s     <= iVoice1;
        v2_s     <= iVoice2;
        lp_s     <= iLP;
        bp_s     <= iBP;
        hp_s     <= iHP;
        acc_filt <= '0;
        acc_dir  <= '0;
        state    <= ACC0;
      end else begin
        case (state)
          IDLE: ;
          ACC0: begin
            if (filt_s[0]) acc_filt <= acc_filt + sx(v0_s);
            else           acc_dir  <= acc_dir + sx(v0_s);
            state <= ACC1;
          end
          ACC1: begin
            if (filt_s[1]) acc_filt <= acc_filt + sx(v1_s);
            else           acc_dir  <= acc_dir + sx(v1_s);
            state <= ACC2;
          end
          ACC2: begin
            // 3OFF mutes voice 2 on the direct path only.
            if (filt_s[2])      acc_filt <= acc_filt + sx(v2_s);
            else if (!mode_s[7]) acc_dir <= acc_dir + sx(v2_s);
            state <= ACC3;
          end
          ACC3: begin
            acc_filt  <= f_ext;
            acc_dir   <= acc_dir + ext_dir;
            oFilterIn <= sat16(f_ext);
            state     <= FLT_LP;
          end
          FLT_LP: begin
            if (mode_s[4]) acc_dir <= acc_dir + sx(lp_s);
            state <= FLT_BP;
          end
          FLT_BP: begin
            if (mode_s[5]) acc_dir <= acc_dir + sx(bp_s);
            state <= FLT_HP;
          end
          FLT_HP: begin
            if (mode_s[6]) acc_dir <= acc_dir + sx(hp_s);
            state <= SAT;
          end
          SAT: begin
            mcand   <= {{VOL_W{mix_s[15]}}, mix_s};
            product <= '0;
            vol_sh  <= mode_s[VOL_W-1:0];
            mul_cnt <= '0;
            state   <= MUL;
          end
          MUL: begin
            if (vol_sh[0]) product <= product + mcand;
            mcand   <= mcand <<< 1;
            vol_sh  <= vol_sh >> 1;
            mul_cnt <= mul_cnt + 1'b1;
            if (mul_cnt == CNT_W'(VOL_W - 1)) state <= DONE;
          end
          DONE: begin
            oOut   <= prod_sh[15:0];
            oValid <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_mixer.sv
// Directed bench for filter_mixer: routing, saturation, 3OFF/volume, abort, write ordering, reset and ext input.
module tb_filter_mixer;

  logic clk = 1'b0;
  logic rstN, clkEn, WR;
  logic [4:0] ADDR;
  logic [7:0] DATA;
  logic signed [15:0] iVoice0, iVoice1, iVoice2, iExt, iLP, iBP, iHP;
  logic signed [15:0] oFilterIn, oOut;
  logic oValid;
  int n_chk = 0;
  int n_fail = 0;

  filter_mixer dut (
    .clk(clk), .rstN(rstN), .clkEn(clkEn), .WR(WR), .ADDR(ADDR), .DATA(DATA),
    .iVoice0(iVoice0), .iVoice1(iVoice1), .iVoice2(iVoice2), .iExt(iExt),
    .iLP(iLP), .iBP(iBP), .iHP(iHP),
    .oFilterIn(oFilterIn), .oOut(oOut), .oValid(oValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [15:0] got, input logic signed [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DATA = d;
    @(negedge clk);
    WR = 1'b0;
  endtask

  // Strobe clkEn, then check oFilterIn after E4 and a single oValid pulse after E13.
  task automatic sample(input string tag, input logic signed [15:0] exp_out, input logic signed [15:0] exp_fin);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0; WR = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 4) chk({tag, " filter_in"}, oFilterIn, exp_fin);
      if (k == 13) begin
        chk1({tag, " valid"}, oValid, 1'b1);
        chk({tag, " out"}, oOut, exp_out);
      end else begin
        chk1({tag, " no_valid"}, oValid, 1'b0);
      end
    end
  endtask

  initial begin
    rstN = 1'b0; clkEn = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
    iVoice0 = 0; iVoice1 = 0; iVoice2 = 0; iExt = 0; iLP = 0; iBP = 0; iHP = 0;
    #12;
    chk("reset out", oOut, 16'sd0);
    chk("reset filter_in", oFilterIn, 16'sd0);
    chk1("reset valid", oValid, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // Routing: voice0 to filter, v1+v2+LP direct = -270, vol 15
    wr(5'h17, 8'h01); wr(5'h18, 8'h1F);
    iVoice0 = 1000; iVoice1 = 200; iVoice2 = 30; iLP = -500; iBP = 7; iHP = 9;
    sample("route", -16'sd254, 16'sd1000);

    // Saturation both ways
    wr(5'h17, 8'h00); wr(5'h18, 8'h0F);
    iVoice0 = 20000; iVoice1 = 20000; iVoice2 = 20000;
    sample("sat_pos", 16'sd30719, 16'sd0);
    iVoice0 = -20000; iVoice1 = -20000; iVoice2 = -20000;
    sample("sat_neg", -16'sd30720, 16'sd0);

    // 3OFF and volume
    iVoice0 = 0; iVoice1 = 0; iVoice2 = 16000;
    wr(5'h18, 8'h88);
    sample("3off", 16'sd0, 16'sd0);
    wr(5'h18, 8'h08);
    sample("vol8", 16'sd8000, 16'sd0);
    wr(5'h18, 8'h00);
    sample("vol0", 16'sd0, 16'sd0);

    // 3OFF does not block voice2 routed into the filter
    wr(5'h17, 8'h04); wr(5'h18, 8'h8F);
    sample("3off_filt", 16'sd0, 16'sd16000);
    wr(5'h17, 8'h00); wr(5'h18, 8'h0F);

    // Abort: second strobe lands on E5; only one pulse, using the new snapshot
    iVoice2 = 0; iVoice0 = 1600;
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk1("abort no_valid", oValid, 1'b0);
      chk("abort hold", oOut, 16'sd0);
    end
    iVoice0 = 3200;
    sample("abort", 16'sd3000, 16'sd0);

    // Write on the strobe edge: old volume 15 used, new volume 8 next time
    iVoice0 = 1600;
    WR = 1'b1; ADDR = 5'h18; DATA = 8'h08;
    sample("wr_same_edge", 16'sd1500, 16'sd0);
    sample("wr_next", 16'sd800, 16'sd0);

    // Reset mid-sample after E6
    wr(5'h17, 8'h01);
    iVoice0 = 1000;
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst filter_in", oFilterIn, 16'sd1000);
    rstN = 1'b0;
    #1;
    chk("mid_rst out", oOut, 16'sd0);
    chk("mid_rst filter_in", oFilterIn, 16'sd0);
    chk1("mid_rst valid", oValid, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk1("post_rst no_valid", oValid, 1'b0);
    end
    // Registers were cleared: volume 0 until rewritten
    sample("post_rst vol0", 16'sd0, 16'sd0);
    wr(5'h18, 8'h0F);
    sample("post_rst", 16'sd937, 16'sd0);

    // External input
    iVoice0 = 0; iExt = 4000;
    wr(5'h17, 8'h08);
`ifdef MIXER_EXT_IN_EN
    sample("ext_filt", 16'sd0, 16'sd4000);
    wr(5'h17, 8'h00);
    sample("ext_dir", 16'sd3750, 16'sd0);
`else
    sample("ext_filt", 16'sd0, 16'sd0);
    wr(5'h17, 8'h00);
    sample("ext_dir", 16'sd0, 16'sd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
